// File: rtl/unit_input_ctrl.sv
// unit_input_ctrl: conditions three raw pushbuttons into the pattern unit's
// A/B selectors and Run enable. Each button is synchronised, debounced and
// edge-detected on the press; outputs are registered.

// Per-channel debouncer: accepts a level change only after DEBOUNCE_CYCLES
// consecutive stable samples and emits one registered pulse per accepted press.
module unit_input_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    HELD,
    ARM_RELEASE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n;

  // State, counter and press-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      press <= press_n;
    end
  end

  // Next-state and counter update from the synchronised level
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (level) begin
          state_n = ARM_PRESS;
          cnt_n   = ONE;
        end
      end
      ARM_PRESS: begin
        if (!level) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HELD: begin
        if (!level) begin
          state_n = ARM_RELEASE;
          cnt_n   = ONE;
        end
      end
      ARM_RELEASE: begin
        if (level) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Press is asserted on the transition ARM_PRESS -> HELD only
  always_comb begin
    press_n = (state == ARM_PRESS) && level && (cnt == LAST);
  end

endmodule

// Top level: synchronisers, three debouncers and the output registers.
module unit_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       btnA,
  input  logic       btnB,
  input  logic       btnRun,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic       Run,
  output logic       changed
);

  // bit 0 = A, bit 1 = B, bit 2 = Run
  logic [2:0] s1, s2;
  logic [2:0] press;

  // Two-flop synchronisers for the raw buttons
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {btnRun, btnB, btnA};
      s2 <= s1;
    end
  end

  unit_input_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_a (
    .clk  (clk),
    .rst  (Reset),
    .level(s2[0]),
    .press(press[0])
  );

  unit_input_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_b (
    .clk  (clk),
    .rst  (Reset),
    .level(s2[1]),
    .press(press[1])
  );

  unit_input_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_run (
    .clk  (clk),
    .rst  (Reset),
    .level(s2[2]),
    .press(press[2])
  );

  // Output registers: independent per channel, simultaneous presses all apply
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      A       <= 2'd0;
      B       <= 2'd0;
      Run     <= 1'b1;
      changed <= 1'b0;
    end else begin
      if (press[0]) A <= A + 2'd1;
      if (press[1]) B <= B + 2'd1;
      if (press[2]) Run <= ~Run;
      changed <= |press;
    end
  end

endmodule

// File: doc/unit_input_ctrl.md
Name: unit_input_ctrl

Overview:
Front-end input conditioner that feeds the pattern unit's A, B and Run inputs from three raw pushbuttons. Each button is synchronised, debounced by a per-channel state machine, and edge-detected on the press. The A and B selectors are 2-bit wrapping counters advanced by one per press; Run toggles per press. Outputs connect straight to unit.A, unit.B and unit.Run.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a press or a release; legal range 2..65535.
CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
clk  input  1  system clock; all logic on the rising edge
Reset  input  1  asynchronous, active-high reset
btnA  input  1  raw pushbutton for the A selector, asynchronous, active-high, may bounce
btnB  input  1  raw pushbutton for the B selector, same properties as btnA
btnRun  input  1  raw pushbutton for Run, same properties as btnA
A  output  2  selector A to the unit; registered
B  output  2  selector B to the unit; registered
Run  output  1  run enable to the unit; registered
changed  output  1  one-cycle pulse whenever A, B or Run updates

Behaviour:
- Reset is asynchronous and active-high. While Reset=1: A=2'd0, B=2'd0, Run=1, changed=0, all synchronisers=0, all debouncers in IDLE with counter=0. Deassertion is not internally synchronised.
- Synchroniser: each btn passes through 2 flops (s1 to s2). The debouncer sees s2 only.
- Debouncer FSM, one independent instance per channel, states IDLE, ARM_PRESS, HELD, ARM_RELEASE:
  - IDLE: s2=1 -> ARM_PRESS, cnt=1.
  - ARM_PRESS: s2=0 -> IDLE, cnt=0. If s2=1 and cnt=DEBOUNCE_CYCLES-1 -> HELD, emit a 1-cycle press pulse; otherwise cnt++.
  - HELD: s2=0 -> ARM_RELEASE, cnt=1.
  - ARM_RELEASE: s2=1 -> HELD, cnt=0. If s2=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE; otherwise cnt++.
  - Exactly one press pulse per accepted press. A held button never repeats. A release does not produce a pulse.
- Latency: from a clean raw 0->1 edge to the output update is 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) cycles.
- Output update on a press pulse:
  - A <= A+1 mod 4, so 3 wraps to 0.
  - B <= B+1 mod 4.
  - Run <= ~Run.
- Simultaneous press pulses on different channels in the same cycle are all applied in that cycle; no priority is needed.
- changed=1 for exactly the cycle in which any output takes its new value; otherwise 0.
- Glitches shorter than DEBOUNCE_CYCLES produce no output change. Bounce during HELD shorter than DEBOUNCE_CYCLES produces no second pulse.
- Reset mid-debounce discards the partial count. After reset, a button still held must pass the full DEBOUNCE_CYCLES before it is accepted.
- No combinational path exists from any btn input to any output.

Test Plan:
1. Reset=1 for 75 ns with buttons toggling, then release Reset -> A=0, B=0, Run=1, changed=0 throughout reset and on the first cycle after.
2. DEBOUNCE_CYCLES=4; press btnA cleanly for 10 cycles, then release -> A goes 0->1 exactly 7 cycles after the raw edge; changed pulses once; B and Run unchanged.
3. DEBOUNCE_CYCLES=4; btnB bounces 1,0,1,1,0 (runs of at most 2 cycles), then stays 1 -> a single B increment after the stable run; five clean presses -> B sequence 1,2,3,0,1 (wrap checked).
4. DEBOUNCE_CYCLES=4; btnRun held 50 cycles -> Run goes 1->0 once with no repeat; release then press again -> Run returns to 1.
5. DEBOUNCE_CYCLES=4; btnA and btnRun rise on the same cycle -> A increments and Run toggles in the same cycle; changed is high for one cycle only.
6. DEBOUNCE_CYCLES=4; btnA high for 3 cycles, assert Reset, keep btnA high and release Reset -> A=0 until 4 stable post-reset samples pass, then A=1.
